// File: rtl/ks_pkg.sv
// Shared sizing for the pipelined Kogge-Stone adder.
package ks_pkg;

    localparam int KS_WIDTH  = 16;
    localparam int KS_LEVELS = $clog2(KS_WIDTH);

    // P/G stage + one stage per prefix level + sum stage.
    function automatic int ks_lat(input int width);
        return $clog2(width) + 2;
    endfunction

endpackage

// File: rtl/ks_prefix_cell.sv
// Kogge-Stone black cell: merges a high group with the group d bits below it.
module ks_prefix_cell (
    input  logic Gh,
    input  logic Ph,
    input  logic Gl,
    input  logic Pl,
    output logic Go,
    output logic Po
);

    assign Go = Gh | (Ph & Gl);
    assign Po = Ph & Pl;

endmodule

// File: rtl/ks_pipe_adder.sv
// Fully pipelined Kogge-Stone adder with valid/ready streaming; a global stall
// freezes every stage while the output beat waits for its consumer.
module ks_pipe_adder
    import ks_pkg::*;
#(
    parameter int WIDTH = KS_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int LAT    = ks_lat(WIDTH);
    localparam int STAGES = LAT - 1;

    logic                          stall;
    logic [STAGES:0]               vld_pipe;
    logic [LEVELS:0][WIDTH-1:0]    g_q;
    logic [LEVELS:0][WIDTH-1:0]    p_q;
    logic [LEVELS:0]               c_q;
    logic [LEVELS-1:0][WIDTH-1:0]  pp_q;
    logic [LEVELS:1][WIDTH-1:0]    g_nx;
    logic [LEVELS-1:1][WIDTH-1:0]  pp_nx;
    logic [WIDTH-1:0]              g0;

    assign stall     = vld_pipe[STAGES] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = vld_pipe[STAGES];

    // Folding cin into G[0] makes every final G[i] the carry out of bit i.
    always_comb begin
        g0    = a & b;
        g0[0] = g0[0] | ((a[0] ^ b[0]) & cin);
    end

    genvar k, i;
    generate
        for (k = 1; k <= LEVELS; k++) begin : g_lvl
            localparam int D = 1 << (k - 1);
            for (i = 0; i < WIDTH; i++) begin : g_bit
                if (i >= D) begin : g_cell
                    logic go, po;
                    ks_prefix_cell u_cell (
                        .Gh (g_q[k-1][i]),
                        .Ph (pp_q[k-1][i]),
                        .Gl (g_q[k-1][i-D]),
                        .Pl (pp_q[k-1][i-D]),
                        .Go (go),
                        .Po (po)
                    );
                    assign g_nx[k][i] = go;
                    // The last level's group propagate has no consumer.
                    if (k < LEVELS) begin : g_pp
                        assign pp_nx[k][i] = po;
                    end else begin : g_pp_last
                        logic po_unused;
                        assign po_unused = po;
                    end
                end else begin : g_pass
                    assign g_nx[k][i] = g_q[k-1][i];
                    if (k < LEVELS) begin : g_pp
                        assign pp_nx[k][i] = pp_q[k-1][i];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            g_q      <= '0;
            p_q      <= '0;
            c_q      <= '0;
            pp_q     <= '0;
            sum      <= '0;
            cout     <= 1'b0;
        end else if (!stall) begin
            vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
            g_q[0]   <= g0;
            pp_q[0]  <= a ^ b;
            p_q[0]   <= a ^ b;
            c_q[0]   <= cin;
            for (int n = 1; n <= LEVELS; n++) begin
                g_q[n] <= g_nx[n];
                p_q[n] <= p_q[n-1];
                c_q[n] <= c_q[n-1];
            end
            for (int n = 1; n < LEVELS; n++) begin
                pp_q[n] <= pp_nx[n];
            end
            sum  <= p_q[LEVELS] ^ {g_q[LEVELS][WIDTH-2:0], c_q[LEVELS]};
            cout <= g_q[LEVELS][WIDTH-1];
        end
    end

endmodule
